// File: rtl/pipe_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctrl_if
//  Description : Handshake bundle between the pipeline stages and the central
//                stall controller (stall requests in, stall/flush out).
//  Revision    : 1.0  initial release
// ============================================================================
interface pipe_stall_ctrl_if #(
   parameter int MC_LEN_W = 6
) ();

   // requests from the pipeline towards the controller
   logic                stallreq_from_if;
   logic                stallreq_from_id;
   logic                ex_mc_start;
   logic [MC_LEN_W-1:0] ex_mc_len;
   logic                excp_valid;
   logic [31:0]         excp_new_pc;

   // controls and status from the controller back to the pipeline
   logic [5:0]          stall;
   logic                flush;
   logic [31:0]         new_pc;
   logic                ex_mc_busy;
   logic                ex_mc_done;
   logic                stall_timeout;
   logic [31:0]         stall_cycles;

   // pipeline side: raises requests, consumes stall/flush
   modport master (
      output stallreq_from_if, stallreq_from_id, ex_mc_start, ex_mc_len,
             excp_valid, excp_new_pc,
      input  stall, flush, new_pc, ex_mc_busy, ex_mc_done,
             stall_timeout, stall_cycles
   );

   // controller side: arbitrates requests, drives stall/flush
   modport slave (
      input  stallreq_from_if, stallreq_from_id, ex_mc_start, ex_mc_len,
             excp_valid, excp_new_pc,
      output stall, flush, new_pc, ex_mc_busy, ex_mc_done,
             stall_timeout, stall_cycles
   );

endinterface
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctrl
//  Description : Central stall/flush controller for the 6-stage core.
//                Merges IF/ID/EX stall requests into one stall vector,
//                sequences multi-cycle EX ops with a busy FSM, drives the
//                exception redirect and keeps stall diagnostics.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stall_ctrl #(
   parameter int MC_LEN_W = 6,
   parameter int TIMEOUT  = 1024,
   parameter int RUN_W    = 16
) (
   input  wire logic        clk,
   input  wire logic        rst,
   pipe_stall_ctrl_if.slave bus
);

   // FSM encoding
   localparam logic [0:0] c_ST_IDLE = 1'b0;
   localparam logic [0:0] c_ST_BUSY = 1'b1;

   // stall patterns: each request freezes its own stage and everything older
   localparam logic [5:0] c_STALL_NONE = 6'b000000;
   localparam logic [5:0] c_STALL_IF   = 6'b000011;
   localparam logic [5:0] c_STALL_ID   = 6'b000111;
   localparam logic [5:0] c_STALL_EX   = 6'b001111;

   localparam logic [MC_LEN_W-1:0] c_LEN_ONE   = MC_LEN_W'(1);
   localparam logic [MC_LEN_W-1:0] c_LEN_ZERO  = '0;
   localparam logic [RUN_W-1:0]    c_RUN_MAX   = '1;
   localparam logic [RUN_W-1:0]    c_RUN_LIMIT = RUN_W'(TIMEOUT - 1);
   localparam logic [31:0]         c_CYC_MAX   = 32'hFFFF_FFFF;

   // state
   logic [0:0]          r_state;
   logic [MC_LEN_W-1:0] r_cnt;
   logic [RUN_W-1:0]    r_run;
   logic                r_timeout;
   logic [31:0]         r_stall_cycles;

   // next-state and combinational controls
   logic [0:0]          w_state_nxt;
   logic [MC_LEN_W-1:0] w_cnt_nxt;
   logic                w_ex_stall;
   logic                w_done;
   logic [5:0]          w_stall;
   logic                w_flush;
   logic                w_stall_any;

   // Multi-cycle sequencer: a start of length L>=2 stalls EX for L-1 cycles,
   // the last BUSY cycle (cnt==1) is the result-ready cycle. An exception
   // aborts the op, and a start coinciding with an exception is dropped.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ex_stall  = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         c_ST_IDLE: begin
            w_cnt_nxt = c_LEN_ZERO;
            if (bus.ex_mc_start && !bus.excp_valid && (bus.ex_mc_len > c_LEN_ONE)) begin
               w_ex_stall  = 1'b1;
               w_state_nxt = c_ST_BUSY;
               w_cnt_nxt   = bus.ex_mc_len - c_LEN_ONE;
            end
         end
         c_ST_BUSY: begin
            if (bus.excp_valid) begin
               w_state_nxt = c_ST_IDLE;
               w_cnt_nxt   = c_LEN_ZERO;
            end else if (r_cnt > c_LEN_ONE) begin
               w_ex_stall = 1'b1;
               w_cnt_nxt  = r_cnt - c_LEN_ONE;
            end else begin
               w_done      = 1'b1;
               w_state_nxt = c_ST_IDLE;
               w_cnt_nxt   = c_LEN_ZERO;
            end
         end
         default: begin
            w_state_nxt = c_ST_IDLE;
            w_cnt_nxt   = c_LEN_ZERO;
         end
      endcase
   end

   // Stall arbitration; lower-priority requests are simply absorbed because
   // requesters keep asserting until their stage is released.
   always_comb begin
      w_stall = c_STALL_NONE;
      if (!rst || bus.excp_valid) begin
         w_stall = c_STALL_NONE;
      end else if (w_ex_stall) begin
         w_stall = c_STALL_EX;
      end else if (bus.stallreq_from_id) begin
         w_stall = c_STALL_ID;
      end else if (bus.stallreq_from_if) begin
         w_stall = c_STALL_IF;
      end
   end

   // Flush/redirect is silent while reset is held
   always_comb begin
      w_flush     = rst && bus.excp_valid;
      w_stall_any = (w_stall != c_STALL_NONE);
   end

   // FSM and multi-cycle counter registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= c_ST_IDLE;
         r_cnt   <= c_LEN_ZERO;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Watchdog: count consecutive stalled cycles, latch a sticky timeout flag
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_run     <= '0;
         r_timeout <= 1'b0;
      end else if (w_stall_any) begin
         if (r_run != c_RUN_MAX) begin
            r_run <= r_run + RUN_W'(1);
         end
         if (r_run >= c_RUN_LIMIT) begin
            r_timeout <= 1'b1;
         end
      end else begin
         r_run <= '0;
      end
   end

   // Saturating total of stalled cycles (flush cycles never stall, so they
   // are never counted)
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_stall_cycles <= '0;
      end else if (w_stall_any && (r_stall_cycles != c_CYC_MAX)) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign bus.stall         = w_stall;
   assign bus.flush         = w_flush;
   assign bus.new_pc        = w_flush ? bus.excp_new_pc : 32'd0;
   assign bus.ex_mc_done    = rst && w_done;
   assign bus.ex_mc_busy    = (r_state == c_ST_BUSY);
   assign bus.stall_timeout = r_timeout;
   assign bus.stall_cycles  = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stall_ctrl
//  Description : Directed self-checking bench for pipe_stall_ctrl
//                (watchdog shortened to TIMEOUT=8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_stall_ctrl;

   logic clk;
   logic rst;
   int   nvec;
   int   nerr;

   pipe_stall_ctrl_if #(.MC_LEN_W(6)) bus ();

   pipe_stall_ctrl #(
      .MC_LEN_W (6),
      .TIMEOUT  (8),
      .RUN_W    (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // one compare point: count it, and on mismatch count and report
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance one cycle and sit 1ns past the edge
   task automatic clk_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.stallreq_from_if = 1'b0;
      bus.stallreq_from_id = 1'b0;
      bus.ex_mc_start      = 1'b0;
      bus.ex_mc_len        = 6'd0;
      bus.excp_valid       = 1'b0;
      bus.excp_new_pc      = 32'd0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_inputs();
      repeat (2) clk_edge();
      rst = 1'b1;
   endtask

   // directed sequence
   initial begin
      int stalled;
      int done_at;
      bit done_seen;
      bit stall_seen;

      nvec = 0;
      nerr = 0;
      rst  = 1'b0;
      clear_inputs();

      // ---------------- reset with all requests high ----------------
      bus.stallreq_from_if = 1'b1;
      bus.stallreq_from_id = 1'b1;
      bus.ex_mc_start      = 1'b1;
      bus.ex_mc_len        = 6'd4;
      repeat (3) clk_edge();
      chk("rst_stall",   32'(bus.stall), 32'h0);
      chk("rst_flush",   32'(bus.flush), 32'h0);
      chk("rst_busy",    32'(bus.ex_mc_busy), 32'h0);
      chk("rst_done",    32'(bus.ex_mc_done), 32'h0);
      chk("rst_cycles",  bus.stall_cycles, 32'h0);
      chk("rst_timeout", 32'(bus.stall_timeout), 32'h0);
      bus.excp_valid  = 1'b1;
      bus.excp_new_pc = 32'hBFC0_0380;
      #1;
      chk("rst_flush_excp", 32'(bus.flush), 32'h0);
      chk("rst_newpc_excp", bus.new_pc, 32'h0);
      // release: only IF keeps requesting
      rst                  = 1'b1;
      bus.excp_valid       = 1'b0;
      bus.excp_new_pc      = 32'd0;
      bus.stallreq_from_id = 1'b0;
      bus.ex_mc_start      = 1'b0;
      #1;
      chk("rel_stall_if", 32'(bus.stall), 32'h03);
      chk("rel_busy",     32'(bus.ex_mc_busy), 32'h0);
      clk_edge();
      bus.stallreq_from_if = 1'b0;
      #1;
      chk("rel_stall_clear", 32'(bus.stall), 32'h0);
      chk("rel_cycles",      bus.stall_cycles, 32'd1);

      // ---------------- multi-cycle L=4 ----------------
      do_reset();
      bus.ex_mc_start = 1'b1;
      bus.ex_mc_len   = 6'd4;
      #1;
      chk("l4_c1_stall", 32'(bus.stall), 32'h0F);
      chk("l4_c1_busy",  32'(bus.ex_mc_busy), 32'h0);
      chk("l4_c1_done",  32'(bus.ex_mc_done), 32'h0);
      clk_edge();
      bus.ex_mc_start = 1'b0;
      #1;
      chk("l4_c2_stall", 32'(bus.stall), 32'h0F);
      chk("l4_c2_busy",  32'(bus.ex_mc_busy), 32'h1);
      chk("l4_c2_done",  32'(bus.ex_mc_done), 32'h0);
      clk_edge();
      chk("l4_c3_stall", 32'(bus.stall), 32'h0F);
      chk("l4_c3_busy",  32'(bus.ex_mc_busy), 32'h1);
      clk_edge();
      chk("l4_c4_stall", 32'(bus.stall), 32'h0);
      chk("l4_c4_busy",  32'(bus.ex_mc_busy), 32'h1);
      chk("l4_c4_done",  32'(bus.ex_mc_done), 32'h1);
      clk_edge();
      chk("l4_after_busy",   32'(bus.ex_mc_busy), 32'h0);
      chk("l4_after_done",   32'(bus.ex_mc_done), 32'h0);
      chk("l4_after_cycles", bus.stall_cycles, 32'd3);

      // ---------------- priority ----------------
      bus.stallreq_from_if = 1'b1;
      bus.stallreq_from_id = 1'b1;
      #1;
      chk("pri_id_if", 32'(bus.stall), 32'h07);
      chk("pri_newpc_idle", bus.new_pc, 32'h0);
      bus.ex_mc_start = 1'b1;
      bus.ex_mc_len   = 6'd3;
      #1;
      chk("pri_ex", 32'(bus.stall), 32'h0F);
      bus.excp_valid  = 1'b1;
      bus.excp_new_pc = 32'hBFC0_0380;
      #1;
      chk("pri_excp_stall", 32'(bus.stall), 32'h0);
      chk("pri_excp_flush", 32'(bus.flush), 32'h1);
      chk("pri_excp_newpc", bus.new_pc, 32'hBFC0_0380);
      clk_edge();
      // the start above coincided with the exception and must be dropped
      bus.excp_valid  = 1'b0;
      bus.excp_new_pc = 32'd0;
      bus.ex_mc_start = 1'b0;
      #1;
      chk("pri_start_dropped", 32'(bus.ex_mc_busy), 32'h0);
      chk("pri_back_to_id",    32'(bus.stall), 32'h07);
      chk("pri_flush_clear",   32'(bus.flush), 32'h0);
      // active op absorbs ID/IF, which reappear once EX is released
      bus.ex_mc_start = 1'b1;
      bus.ex_mc_len   = 6'd3;
      clk_edge();
      bus.ex_mc_start = 1'b0;
      #1;
      chk("pri_busy_ex", 32'(bus.stall), 32'h0F);
      clk_edge();
      chk("pri_done_id",   32'(bus.stall), 32'h07);
      chk("pri_done_flag", 32'(bus.ex_mc_done), 32'h1);
      clk_edge();
      clear_inputs();

      // ---------------- flush in the middle of an op ----------------
      do_reset();
      bus.ex_mc_start = 1'b1;
      bus.ex_mc_len   = 6'd10;
      clk_edge();
      bus.ex_mc_start = 1'b0;
      clk_edge();
      bus.excp_valid  = 1'b1;
      bus.excp_new_pc = 32'h8000_0100;
      #1;
      chk("mid_flush",       32'(bus.flush), 32'h1);
      chk("mid_flush_stall", 32'(bus.stall), 32'h0);
      chk("mid_flush_pc",    bus.new_pc, 32'h8000_0100);
      chk("mid_flush_done",  32'(bus.ex_mc_done), 32'h0);
      clk_edge();
      bus.excp_valid  = 1'b0;
      bus.excp_new_pc = 32'd0;
      #1;
      chk("mid_after_busy",  32'(bus.ex_mc_busy), 32'h0);
      chk("mid_after_stall", 32'(bus.stall), 32'h0);
      done_seen  = 1'b0;
      stall_seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (bus.ex_mc_done) done_seen = 1'b1;
         if (bus.stall != 6'd0) stall_seen = 1'b1;
         clk_edge();
      end
      chk("mid_no_done",  32'(done_seen), 32'h0);
      chk("mid_no_stall", 32'(stall_seen), 32'h0);
      chk("mid_cycles",   bus.stall_cycles, 32'd2);

      // ---------------- edge lengths 0 and 1 ----------------
      bus.ex_mc_start = 1'b1;
      bus.ex_mc_len   = 6'd0;
      #1;
      chk("len0_stall", 32'(bus.stall), 32'h0);
      clk_edge();
      bus.ex_mc_len = 6'd1;
      #1;
      chk("len0_busy",  32'(bus.ex_mc_busy), 32'h0);
      chk("len1_stall", 32'(bus.stall), 32'h0);
      clk_edge();
      bus.ex_mc_start = 1'b0;
      #1;
      chk("len1_busy", 32'(bus.ex_mc_busy), 32'h0);
      chk("len1_done", 32'(bus.ex_mc_done), 32'h0);

      // ---------------- length 63 ----------------
      do_reset();
      bus.ex_mc_start = 1'b1;
      bus.ex_mc_len   = 6'd63;
      stalled = 0;
      done_at = -1;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (bus.stall != 6'd0) stalled++;
         if (bus.ex_mc_done) begin
            done_at = i;
            break;
         end
         clk_edge();
         bus.ex_mc_start = 1'b0;
      end
      clk_edge();
      bus.ex_mc_start = 1'b0;
      chk("len63_done_at", 32'(done_at), 32'd62);
      chk("len63_stalled", 32'(stalled), 32'd62);
      chk("len63_cycles",  bus.stall_cycles, 32'd62);

      // ---------------- second start while BUSY ----------------
      stalled = 0;
      done_at = -1;
      for (int i = 0; i < 40; i++) begin
         bus.ex_mc_start = (i == 0) || (i == 2);
         bus.ex_mc_len   = (i == 0) ? 6'd5 : 6'd9;
         #1;
         if (bus.stall != 6'd0) stalled++;
         if (bus.ex_mc_done) begin
            done_at = i;
            break;
         end
         clk_edge();
      end
      clk_edge();
      clear_inputs();
      #1;
      chk("restart_done_at", 32'(done_at), 32'd4);
      chk("restart_stalled", 32'(stalled), 32'd4);
      chk("restart_busy",    32'(bus.ex_mc_busy), 32'h0);

      // ---------------- watchdog, 8 consecutive stalls ----------------
      do_reset();
      bus.stallreq_from_id = 1'b1;
      repeat (7) clk_edge();
      chk("wd_edge7", 32'(bus.stall_timeout), 32'h0);
      clk_edge();
      chk("wd_edge8", 32'(bus.stall_timeout), 32'h1);
      bus.stallreq_from_id = 1'b0;
      repeat (3) clk_edge();
      chk("wd_sticky",       32'(bus.stall_timeout), 32'h1);
      chk("wd_sticky_stall", 32'(bus.stall), 32'h0);

      // ---------------- watchdog, 7 + gap + 7 ----------------
      do_reset();
      chk("wd_cleared", 32'(bus.stall_timeout), 32'h0);
      bus.stallreq_from_id = 1'b1;
      repeat (7) clk_edge();
      bus.stallreq_from_id = 1'b0;
      clk_edge();
      bus.stallreq_from_id = 1'b1;
      repeat (7) clk_edge();
      bus.stallreq_from_id = 1'b0;
      repeat (2) clk_edge();
      chk("wd_split",        32'(bus.stall_timeout), 32'h0);
      chk("wd_split_cycles", bus.stall_cycles, 32'd14);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   // hard stop in case the sequence above stalls on a broken DUT
   initial begin
      #200000;
      $display("FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "bench time limit reached");
   end

endmodule
`default_nettype wire

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central pipeline controller for the 6-stage core (PC, IF, ID, EX, MEM, WB). It merges stall requests from IF, ID and EX into the shared stall[5:0] vector consumed by every pipeline register. It sequences multi-cycle EX operations (mul-acc, divide) with an internal busy FSM and cycle counter. It also drives the exception flush/redirect and keeps stall diagnostics (watchdog, cycle count).

Parameters:
MC_LEN_W, 6, width of multi-cycle length field (max EX occupancy 2^MC_LEN_W-1 cycles)
TIMEOUT, 1024, consecutive stalled cycles that set stall_timeout
RUN_W, 16, width of consecutive-stall run counter (TIMEOUT must be < 2^RUN_W)

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-low (rst==0 resets)
stallreq_from_if  in  1  IF not ready (fetch wait)
stallreq_from_id  in  1  ID hazard (load-use)
ex_mc_start  in  1  EX begins a multi-cycle op this cycle
ex_mc_len  in  MC_LEN_W  total EX occupancy cycles of that op
excp_valid  in  1  exception/eret committed from MEM
excp_new_pc  in  32  redirect target
stall  out  6  bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = stop
flush  out  1  clear all pipeline registers
new_pc  out  32  redirect PC, valid when flush=1
ex_mc_busy  out  1  FSM in BUSY
ex_mc_done  out  1  final (result-ready) cycle of multi-cycle op
stall_timeout  out  1  sticky watchdog flag
stall_cycles  out  32  saturating count of cycles with stall!=0

Behaviour:
- stall, flush, new_pc, ex_mc_done are combinational from inputs + state; other outputs are registered.
- Reset (rst==0 at posedge): state=IDLE, cnt=0, run=0, stall_timeout=0, stall_cycles=0. While rst==0, all combinational outputs are forced to 0 (stall=0, flush=0, new_pc=0, ex_mc_done=0).
- FSM states: IDLE, BUSY. cnt is MC_LEN_W bits.
- IDLE, ex_mc_start=1, L=ex_mc_len: L<=1 (0 treated as 1) means single-cycle, no stall, stay IDLE. L>=2 raises ex_stall in this cycle, next state BUSY, cnt<=L-1.
- BUSY: ex_stall=1 while cnt>1, and cnt decrements each cycle. At cnt==1: ex_stall=0, ex_mc_done=1, next state IDLE. EX therefore holds the op for exactly L cycles (L-1 stalled cycles).
- ex_mc_start is ignored while BUSY.
- Stall priority (highest first):
  - excp_valid gives stall=000000.
  - ex_stall gives 001111.
  - stallreq_from_id gives 000111.
  - stallreq_from_if gives 000011.
  - Otherwise stall=000000.
- Flush: excp_valid=1 gives flush=1 and new_pc=excp_new_pc in the same cycle. Otherwise flush=0 and new_pc=0.
- Flush during BUSY or start cycle: ex_mc_done=0, next state IDLE, cnt<=0 (the op is aborted).
- Simultaneous start + excp_valid: the start is discarded and the FSM stays IDLE.
- Lower-priority requests coinciding with ex_stall are absorbed (not queued). Requesters hold their request until they see no stall on their own stage.
- Watchdog: run<=run+1 (saturating) when stall!=0, else run<=0. When run reaches TIMEOUT-1 and stall!=0, stall_timeout<=1. It stays 1 until reset.
- stall_cycles increments when stall!=0 and saturates at 0xFFFFFFFF. Flush cycles are not counted.

Test Plan:
- Reset: hold rst=0 3 cycles with all requests high, then release. Required: stall=0, flush=0, ex_mc_busy=0, stall_cycles=0 during reset. Next cycle stall=001111 only if start is also applied, else 000011 for stallreq_from_if.
- Multi-cycle L=4: pulse ex_mc_start with len 4. Required: stall=001111 for 3 consecutive cycles, then 000000 with ex_mc_done=1 on the 4th. ex_mc_busy=1 on cycles 2-4. stall_cycles=3.
- Priority: stallreq_from_if=1 and stallreq_from_id=1 together gives 000111. Adding an active multi-cycle op gives 001111. Raising excp_valid gives 000000 with flush=1 and new_pc=0xBFC00380.
- Flush mid-op: start L=10, assert excp_valid on the 3rd stalled cycle. Required: flush=1 that cycle. Next cycle ex_mc_busy=0 and stall=0, and ex_mc_done is never asserted.
- Edge lengths: len 0 and len 1 give no stall and FSM stays IDLE. Len 63 gives 62 stalled cycles. A second start while BUSY is ignored and the done timing is unchanged.
- Watchdog: TIMEOUT=8, hold stallreq_from_id=1 for 8 cycles. Required: stall_timeout=1 after the 8th edge and stays 1 after the request drops. If the request is held only 7 cycles, dropped 1 cycle, then held 7 more, stall_timeout stays 0.
